lcd_cell_painter: RTL and testbench
===================================

Name: lcd_cell_painter

Overview:
- Sits directly downstream of the map-scan/diff stage of the snake image generator.
- When the scanner raises `diff` for a grid cell, this block latches that cell's x, y and obj_code. It then paints that cell on a 320x240 ILI9341-class LCD over an 8080-style 8-bit parallel bus.
- On completion it pulses `cmd_done` back to the scanner, which then resumes scanning.
- Each grid cell maps to a CELL_PX x CELL_PX pixel square (16x12 grid -> 320x240).

Parameters:
- CELL_PX, 20, side of one grid cell in pixels; a cell is CELL_PX*CELL_PX pixels.
- GRID_ROWS, 12, number of valid rows; requests with y >= GRID_ROWS are rejected.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- diff  in  1  level request from the scanner: "paint cell (x,y)"
- x  in  4  cell column, 0..15
- y  in  4  cell row, 0..GRID_ROWS-1
- obj_code  in  3  object in the cell
- lcd_d  out  8  parallel data bus
- lcd_dcx  out  1  0 = command byte, 1 = data byte
- lcd_wrx  out  1  write strobe; the LCD latches on the rising edge
- lcd_csx  out  1  chip select, active low
- busy  out  1  high from the cycle after accept until cmd_done
- cmd_done  out  1  one-cycle completion pulse to the scanner

Behaviour:
- Reset values, asynchronous on nrst=0:
  - lcd_d=0x00, lcd_dcx=1, lcd_wrx=1, lcd_csx=1, busy=0, cmd_done=0.
  - State=IDLE, all counters cleared.
  - Reset mid-transfer aborts silently: no cmd_done is issued.
- All outputs are registered.
- States: IDLE, SEND, DONE.
- IDLE:
  - On a clk edge with diff=1 and y<GRID_ROWS: latch x, y, obj_code, go to SEND.
  - On a clk edge with diff=1 and y>=GRID_ROWS: go to DONE without touching the bus.
  - diff is sampled only in IDLE. Changes on x, y or obj_code after the accept edge have no effect.
- SEND:
  - Every byte takes two cycles. Phase A: lcd_wrx=0, with lcd_d and lcd_dcx valid. Phase B: lcd_wrx=1, with lcd_d and lcd_dcx held.
  - lcd_csx=0 throughout SEND.
- Byte sequence, in this order:
  1. CASET 0x2A (dcx=0).
  2. SC[15:8], SC[7:0], EC[15:8], EC[7:0] (dcx=1), where SC=x*CELL_PX and EC=SC+CELL_PX-1.
  3. PASET 0x2B (dcx=0).
  4. SP hi, SP lo, EP hi, EP lo (dcx=1), where SP=y*CELL_PX and EP=SP+CELL_PX-1.
  5. RAMWR 0x2C (dcx=0).
  6. CELL_PX^2 pixels, each sent as colour[15:8] then colour[7:0] (dcx=1).
- Coordinate arithmetic is 9-bit unsigned, zero-extended to 16 bits on the bus.
- Colour is RGB565, selected from the latched obj_code:
  - EMPTY 0x0000
  - BODY 0x07E0
  - HEAD 0x03E0
  - APPLE 0xF800
  - BORDER 0xFFFF
  - codes 5-7 0xF81F (error magenta)
- Totals with the default CELL_PX: 11 + 800 = 811 bytes, 1622 cycles.
- Timing, counting cycle 1 as the cycle after the accept edge:
  - Bytes occupy cycles 1..1622.
  - DONE is cycle 1623: cmd_done=1, lcd_csx=1, lcd_wrx=1, busy=0.
  - The block is back in IDLE from cycle 1624.
- Rejected request: DONE is cycle 1, with cmd_done=1 and lcd_csx held at 1.
- The scanner must drop diff in the cycle after cmd_done. If diff is still high in IDLE, it is treated as a new request; this is legal and repaints the cell.
- busy=1 in SEND only.

Decomposition:
- Package snake_lcd_pkg holds:
  - obj_code constants: EMPTY=0, BODY=1, HEAD=2, APPLE=3, BORDER=4.
  - RGB565 colour constants.
  - LCD opcodes CASET, PASET, RAMWR.
  - Default CELL_PX.
  - The state enum.
- Sub-module lcd_byte_writer:
  - Two-phase strobe serializer.
  - Inputs: start, byte, dc. Outputs: lcd_d, lcd_dcx, lcd_wrx, ready.
- The parent contains the sequencer FSM, the byte index and pixel counters, and the coordinate and colour generation.

Test Plan:
1. Reset: assert nrst=0 mid-cycle -> all outputs take their reset values immediately, without waiting for clk.
2. diff=1, x=0, y=0, obj_code=4 -> bytes 2A,00,00,00,13,2B,00,00,00,13,2C, then 800 bytes 0xFF; dcx=0 only on the 3 opcodes; cmd_done high in cycle 1623 only.
3. x=15, y=11, obj_code=3 -> CASET data 01,2C,01,3F; PASET data 00,DC,00,EF; pixels F8,00 repeated 400 times; byte count 811.
4. x=3, y=12 -> no wrx/csx activity; cmd_done=1 in cycle 1 after accept; busy stays 0.
5. Accept x=2, y=5, obj_code=1, then change x to 9, obj_code to 2 and toggle diff during SEND -> the transfer still uses SC=40, SP=100 and colour 0x07E0; exactly one cmd_done.
6. nrst pulsed at cycle 500 of a transfer -> outputs idle at once, no cmd_done; the next request produces a full 811-byte sequence.

Source files
------------

// File: rtl/lcd_cell_painter_pkg.sv
// Shared constants for the snake LCD cell painter.
// Object codes, RGB565 colours, ILI9341 opcodes, sequencer states.
package snake_lcd_pkg;

  localparam int unsigned CELL_PX_DEF = 20;

  localparam logic [2:0] OBJ_EMPTY  = 3'd0;
  localparam logic [2:0] OBJ_BODY   = 3'd1;
  localparam logic [2:0] OBJ_HEAD   = 3'd2;
  localparam logic [2:0] OBJ_APPLE  = 3'd3;
  localparam logic [2:0] OBJ_BORDER = 3'd4;

  localparam logic [15:0] RGB_EMPTY  = 16'h0000;
  localparam logic [15:0] RGB_BODY   = 16'h07E0;
  localparam logic [15:0] RGB_HEAD   = 16'h03E0;
  localparam logic [15:0] RGB_APPLE  = 16'hF800;
  localparam logic [15:0] RGB_BORDER = 16'hFFFF;
  localparam logic [15:0] RGB_ERROR  = 16'hF81F;

  localparam logic [7:0] OP_CASET = 8'h2A;
  localparam logic [7:0] OP_PASET = 8'h2B;
  localparam logic [7:0] OP_RAMWR = 8'h2C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } state_e;

  function automatic logic [15:0] obj_colour(
    input logic [2:0] code
  );
    logic [15:0] c;
    c = RGB_ERROR;
    unique case (code)
      OBJ_EMPTY:  c = RGB_EMPTY;
      OBJ_BODY:   c = RGB_BODY;
      OBJ_HEAD:   c = RGB_HEAD;
      OBJ_APPLE:  c = RGB_APPLE;
      OBJ_BORDER: c = RGB_BORDER;
      default:    c = RGB_ERROR;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/lcd_cell_painter_if.sv
// Scanner request/completion signals plus the 8080 LCD bus.
// slave: painter side; master: scanner / LCD model side.
interface lcd_cell_painter_if;

  logic       diff;
  logic [3:0] x;
  logic [3:0] y;
  logic [2:0] obj_code;
  logic [7:0] lcd_d;
  logic       lcd_dcx;
  logic       lcd_wrx;
  logic       lcd_csx;
  logic       busy;
  logic       cmd_done;

  modport slave (
    input  diff, x, y, obj_code,
    output lcd_d, lcd_dcx, lcd_wrx,
    output lcd_csx, busy, cmd_done
  );

  modport master (
    output diff, x, y, obj_code,
    input  lcd_d, lcd_dcx, lcd_wrx,
    input  lcd_csx, busy, cmd_done
  );

endinterface

// File: rtl/lcd_cell_painter_byte_writer.sv
// Two-phase 8080 write strobe: wrx low, then high, data held both.
// Ports: start_i/byte_i/dc_i in; lcd_d_o/lcd_dcx_o/lcd_wrx_o/ready_o out.
module lcd_byte_writer (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  input  logic       dc_i,
  output logic [7:0] lcd_d_o,
  output logic       lcd_dcx_o,
  output logic       lcd_wrx_o,
  output logic       ready_o
);

  logic [7:0] d_q, d_d;
  logic       dcx_q, dcx_d;
  logic       wrx_q, wrx_d;

  always_comb begin
    d_d   = d_q;
    dcx_d = dcx_q;
    wrx_d = 1'b1;
    // wrx high means phase B (or idle): a new byte may start
    if (start_i && wrx_q) begin
      d_d   = byte_i;
      dcx_d = dc_i;
      wrx_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      d_q   <= 8'h00;
      dcx_q <= 1'b1;
      wrx_q <= 1'b1;
    end else begin
      d_q   <= d_d;
      dcx_q <= dcx_d;
      wrx_q <= wrx_d;
    end
  end

  assign lcd_d_o   = d_q;
  assign lcd_dcx_o = dcx_q;
  assign lcd_wrx_o = wrx_q;
  assign ready_o   = wrx_q;

endmodule

// File: rtl/lcd_cell_painter.sv
// Paints one grid cell on an ILI9341-class LCD per scanner request.
// Ports: clk, nrst, bus (scanner request/done + 8080 LCD bus).
module lcd_cell_painter
  import snake_lcd_pkg::*;
#(
  parameter int unsigned CELL_PX   = CELL_PX_DEF,
  parameter int unsigned GRID_ROWS = 12
) (
  input  logic                 clk,
  input  logic                 nrst,
  lcd_cell_painter_if.slave    bus
);

  localparam int unsigned TOTAL = 11 + 2 * CELL_PX * CELL_PX;
  localparam int unsigned CW    = $clog2(TOTAL + 1);
  localparam logic [8:0]  PX9   = 9'(CELL_PX);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    x_q, x_d;
  logic [3:0]    y_q, y_d;
  logic [2:0]    obj_q, obj_d;
  logic          csx_q, csx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          wr_start;
  logic          wr_ready;
  logic [7:0]    byte_sel;
  logic          dc_sel;
  logic          y_ok;

  logic [8:0]    sc, ec, sp, ep;
  logic [15:0]   colour;

  assign sc     = {5'd0, x_q} * PX9;
  assign ec     = sc + PX9 - 9'd1;
  assign sp     = {5'd0, y_q} * PX9;
  assign ep     = sp + PX9 - 9'd1;
  assign colour = obj_colour(obj_q);
  assign y_ok   = {28'd0, bus.y} < GRID_ROWS;

  // cnt_q is the index of the next byte to issue
  always_comb begin
    byte_sel = 8'h00;
    dc_sel   = 1'b1;
    unique case (1'b1)
      (cnt_q == CW'(0)): begin
        byte_sel = OP_CASET;
        dc_sel   = 1'b0;
      end
      (cnt_q == CW'(1)):  byte_sel = {7'd0, sc[8]};
      (cnt_q == CW'(2)):  byte_sel = sc[7:0];
      (cnt_q == CW'(3)):  byte_sel = {7'd0, ec[8]};
      (cnt_q == CW'(4)):  byte_sel = ec[7:0];
      (cnt_q == CW'(5)): begin
        byte_sel = OP_PASET;
        dc_sel   = 1'b0;
      end
      (cnt_q == CW'(6)):  byte_sel = {7'd0, sp[8]};
      (cnt_q == CW'(7)):  byte_sel = sp[7:0];
      (cnt_q == CW'(8)):  byte_sel = {7'd0, ep[8]};
      (cnt_q == CW'(9)):  byte_sel = ep[7:0];
      (cnt_q == CW'(10)): begin
        byte_sel = OP_RAMWR;
        dc_sel   = 1'b0;
      end
      default: begin
        // pixel bytes start at odd index 11: odd = high byte
        byte_sel = cnt_q[0] ? colour[15:8] : colour[7:0];
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    obj_d    = obj_q;
    csx_d    = csx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wr_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.diff) begin
          if (y_ok) begin
            x_d      = bus.x;
            y_d      = bus.y;
            obj_d    = bus.obj_code;
            state_d  = ST_SEND;
            csx_d    = 1'b0;
            busy_d   = 1'b1;
            wr_start = 1'b1;
            cnt_d    = CW'(1);
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (wr_ready) begin
          if (cnt_q == CW'(TOTAL)) begin
            state_d = ST_DONE;
            csx_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            wr_start = 1'b1;
            cnt_d    = cnt_q + CW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        csx_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      x_q     <= 4'd0;
      y_q     <= 4'd0;
      obj_q   <= 3'd0;
      csx_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      obj_q   <= obj_d;
      csx_q   <= csx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  lcd_byte_writer u_writer (
    .clk       (clk),
    .nrst      (nrst),
    .start_i   (wr_start),
    .byte_i    (byte_sel),
    .dc_i      (dc_sel),
    .lcd_d_o   (bus.lcd_d),
    .lcd_dcx_o (bus.lcd_dcx),
    .lcd_wrx_o (bus.lcd_wrx),
    .ready_o   (wr_ready)
  );

  assign bus.lcd_csx  = csx_q;
  assign bus.busy     = busy_q;
  assign bus.cmd_done = done_q;

endmodule

// File: tb/tb_lcd_cell_painter.sv
// Directed self-checking bench for lcd_cell_painter.
// Captures LCD bytes per transfer and checks against hand values.
module tb_lcd_cell_painter;

  logic clk = 1'b0;
  logic nrst = 1'b1;

  lcd_cell_painter_if bus ();

  lcd_cell_painter #(
    .CELL_PX   (20),
    .GRID_ROWS (12)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] cap_d  [0:1023];
  logic       cap_dc [0:1023];
  int         cap_n, done_cnt, done_cyc;
  int         busy_n, csx_n, wrx_low_n, hold_err;
  logic [2:0] done_snap;

  localparam logic [12:0] IDLE_OUT = {8'h00, 5'b11100};

  function automatic logic [12:0] outs();
    return {bus.lcd_d, bus.lcd_dcx, bus.lcd_wrx,
            bus.lcd_csx, bus.busy, bus.cmd_done};
  endfunction

  function automatic logic [87:0] pack_hdr();
    logic [87:0] r;
    r = '0;
    for (int i = 0; i < 11; i++) r = {r[79:0], cap_d[i]};
    return r;
  endfunction

  function automatic logic [10:0] pack_dcx();
    logic [10:0] r;
    r = '0;
    for (int i = 0; i < 11; i++) r = {r[9:0], cap_dc[i]};
    return r;
  endfunction

  function automatic int pix_err(input logic [15:0] col);
    int e;
    logic [7:0] want;
    e = 0;
    if (cap_n < 811) return 800;
    for (int i = 0; i < 800; i++) begin
      want = (i % 2 == 0) ? col[15:8] : col[7:0];
      if (cap_d[11+i] !== want || cap_dc[11+i] !== 1'b1) e++;
    end
    return e;
  endfunction

  task automatic request(input logic [3:0] xx, input logic [3:0] yy,
                         input logic [2:0] oo);
    @(negedge clk);
    bus.x        = xx;
    bus.y        = yy;
    bus.obj_code = oo;
    bus.diff     = 1'b1;
    @(posedge clk);
    #1 bus.diff = 1'b0;
  endtask

  task automatic collect(input int ncyc, input bit mutate);
    logic       pw;
    logic [7:0] pd;
    logic       pdc;
    cap_n = 0; done_cnt = 0; done_cyc = 0;
    busy_n = 0; csx_n = 0; wrx_low_n = 0; hold_err = 0;
    done_snap = 3'b000;
    pw = 1'b1; pd = 8'h00; pdc = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (bus.lcd_wrx === 1'b0) begin
        if (pw === 1'b0) hold_err++;
        if (cap_n < 1024) begin
          cap_d[cap_n]  = bus.lcd_d;
          cap_dc[cap_n] = bus.lcd_dcx;
        end
        cap_n++;
        wrx_low_n++;
      end else if (pw === 1'b0 &&
                   (bus.lcd_d !== pd || bus.lcd_dcx !== pdc)) begin
        hold_err++;
      end
      pw  = bus.lcd_wrx;
      pd  = bus.lcd_d;
      pdc = bus.lcd_dcx;
      if (bus.busy === 1'b1) busy_n++;
      if (bus.lcd_csx === 1'b0) csx_n++;
      if (bus.cmd_done === 1'b1) begin
        done_cnt++;
        done_cyc  = c;
        done_snap = {bus.lcd_csx, bus.lcd_wrx, bus.busy};
      end
      if (mutate) begin
        if (c == 5) begin
          bus.x        = 4'd9;
          bus.obj_code = 3'd2;
        end
        if (c == 10) bus.diff = 1'b1;
        if (c == 20) bus.diff = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    checks++;
    if (outs() !== IDLE_OUT) begin
      errors++;
      $display("FAIL reset_async: got %h want %h", outs(), IDLE_OUT);
    end
    @(posedge clk);
    #1;
    checks++;
    if (outs() !== IDLE_OUT) begin
      errors++;
      $display("FAIL reset_held: got %h want %h", outs(), IDLE_OUT);
    end
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_border_cell();
    request(4'd0, 4'd0, 3'd4);
    collect(1630, 1'b0);
    checks++;
    if (pack_hdr() !== 88'h2A_00_00_00_13_2B_00_00_00_13_2C) begin
      errors++;
      $display("FAIL border_hdr: got %h want %h", pack_hdr(),
               88'h2A_00_00_00_13_2B_00_00_00_13_2C);
    end
    checks++;
    if (pack_dcx() !== 11'b01111011110) begin
      errors++;
      $display("FAIL border_dcx: got %b want %b", pack_dcx(),
               11'b01111011110);
    end
    checks++;
    if (pix_err(16'hFFFF) !== 0) begin
      errors++;
      $display("FAIL border_pix: got %0d bad want 0", pix_err(16'hFFFF));
    end
    checks++;
    if (cap_n !== 811) begin
      errors++;
      $display("FAIL border_count: got %0d want 811", cap_n);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 1623) begin
      errors++;
      $display("FAIL border_done: got %0d@%0d want 1@1623",
               done_cnt, done_cyc);
    end
    checks++;
    if (done_snap !== 3'b110) begin
      errors++;
      $display("FAIL border_done_outs: got %b want 110", done_snap);
    end
    checks++;
    if (busy_n !== 1622 || csx_n !== 1622) begin
      errors++;
      $display("FAIL border_busy_csx: got %0d/%0d want 1622/1622",
               busy_n, csx_n);
    end
    checks++;
    if (hold_err !== 0) begin
      errors++;
      $display("FAIL border_strobe: got %0d bad phases want 0", hold_err);
    end
  endtask

  task automatic test_corner_apple();
    request(4'd15, 4'd11, 3'd3);
    collect(1630, 1'b0);
    checks++;
    if (pack_hdr() !== 88'h2A_01_2C_01_3F_2B_00_DC_00_EF_2C) begin
      errors++;
      $display("FAIL corner_hdr: got %h want %h", pack_hdr(),
               88'h2A_01_2C_01_3F_2B_00_DC_00_EF_2C);
    end
    checks++;
    if (pix_err(16'hF800) !== 0) begin
      errors++;
      $display("FAIL corner_pix: got %0d bad want 0", pix_err(16'hF800));
    end
    checks++;
    if (cap_n !== 811) begin
      errors++;
      $display("FAIL corner_count: got %0d want 811", cap_n);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 1623) begin
      errors++;
      $display("FAIL corner_done: got %0d@%0d want 1@1623",
               done_cnt, done_cyc);
    end
  endtask

  task automatic test_reject();
    request(4'd3, 4'd12, 3'd1);
    collect(20, 1'b0);
    checks++;
    if (wrx_low_n !== 0 || csx_n !== 0) begin
      errors++;
      $display("FAIL reject_bus: got wrx %0d csx %0d want 0/0",
               wrx_low_n, csx_n);
    end
    checks++;
    if (busy_n !== 0) begin
      errors++;
      $display("FAIL reject_busy: got %0d want 0", busy_n);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 1) begin
      errors++;
      $display("FAIL reject_done: got %0d@%0d want 1@1",
               done_cnt, done_cyc);
    end
  endtask

  task automatic test_input_freeze();
    request(4'd2, 4'd5, 3'd1);
    collect(1630, 1'b1);
    checks++;
    if (pack_hdr() !== 88'h2A_00_28_00_3B_2B_00_64_00_77_2C) begin
      errors++;
      $display("FAIL freeze_hdr: got %h want %h", pack_hdr(),
               88'h2A_00_28_00_3B_2B_00_64_00_77_2C);
    end
    checks++;
    if (pix_err(16'h07E0) !== 0) begin
      errors++;
      $display("FAIL freeze_pix: got %0d bad want 0", pix_err(16'h07E0));
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 1623) begin
      errors++;
      $display("FAIL freeze_done: got %0d@%0d want 1@1623",
               done_cnt, done_cyc);
    end
  endtask

  task automatic test_reset_abort();
    request(4'd4, 4'd7, 3'd3);
    collect(500, 1'b0);
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (outs() !== IDLE_OUT) begin
      errors++;
      $display("FAIL abort_idle: got %h want %h", outs(), IDLE_OUT);
    end
    @(negedge clk);
    @(negedge clk);
    nrst = 1'b1;
    collect(1700, 1'b0);
    checks++;
    if (done_cnt !== 0 || wrx_low_n !== 0 || busy_n !== 0) begin
      errors++;
      $display("FAIL abort_quiet: got done %0d wrx %0d busy %0d want 0",
               done_cnt, wrx_low_n, busy_n);
    end
    request(4'd1, 4'd1, 3'd0);
    collect(1630, 1'b0);
    checks++;
    if (cap_n !== 811) begin
      errors++;
      $display("FAIL after_abort_count: got %0d want 811", cap_n);
    end
    checks++;
    if (pack_hdr() !== 88'h2A_00_14_00_27_2B_00_14_00_27_2C) begin
      errors++;
      $display("FAIL after_abort_hdr: got %h want %h", pack_hdr(),
               88'h2A_00_14_00_27_2B_00_14_00_27_2C);
    end
    checks++;
    if (pix_err(16'h0000) !== 0) begin
      errors++;
      $display("FAIL after_abort_pix: got %0d bad want 0",
               pix_err(16'h0000));
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== 1623) begin
      errors++;
      $display("FAIL after_abort_done: got %0d@%0d want 1@1623",
               done_cnt, done_cyc);
    end
  endtask

  initial begin
    bus.diff     = 1'b0;
    bus.x        = 4'd0;
    bus.y        = 4'd0;
    bus.obj_code = 3'd0;
    test_reset();
    test_border_cell();
    test_corner_apple();
    test_reject();
    test_input_freeze();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
